// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller and its shifter.
package spi_pkg;

    localparam int FRAME_W  = 10;
    localparam int DATA_W   = 8;
    localparam int RX_IDX_W = $clog2(DATA_W);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef logic [3:0] cnt_t;
    typedef logic [7:0] tmr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT,
        ST_RD_WAIT,
        ST_RECV,
        ST_GAP
    } state_e;

    // Read-data frames carry no payload; the slave expects zeros there.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0] c,
                                                       input logic [DATA_W-1:0] d);
        return {c, (c == CMD_RD_DATA) ? {DATA_W{1'b0}} : d};
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first frame serialiser and LSB-first byte deserialiser sharing one bit counter.
module spi_shift_reg
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               a_rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    input  logic               shift_en,
    input  logic               cnt_rst,
    input  logic               capture_en,
    input  logic               serial_in,
    output logic               serial_out,
    output logic [DATA_W-1:0]  rx_next,
    output logic               tx_last,
    output logic               rx_last
);

    logic [FRAME_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    cnt_t                cnt_q, cnt_d;
    logic [RX_IDX_W-1:0] rx_idx;

    // Counter holds the 1-based number of the bit currently on the wire.
    assign rx_idx     = RX_IDX_W'(cnt_q - cnt_t'(1));
    assign serial_out = tx_q[FRAME_W-1];
    assign tx_last    = (cnt_q == cnt_t'(FRAME_W));
    assign rx_last    = (cnt_q == cnt_t'(DATA_W));

    always_comb begin
        rx_next         = rx_q;
        rx_next[rx_idx] = serial_in;
    end

    always_comb begin
        tx_d  = tx_q;
        rx_d  = rx_q;
        cnt_d = cnt_q;
        if (load) begin
            tx_d  = frame;
            cnt_d = cnt_t'(1);
        end else if (shift_en) begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
            if (!tx_last) cnt_d = cnt_q + cnt_t'(1);
        end else if (cnt_rst) begin
            cnt_d = cnt_t'(1);
        end else if (capture_en) begin
            rx_d = rx_next;
            if (!rx_last) cnt_d = cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            tx_q  <= '0;
            rx_q  <= '0;
            cnt_q <= '0;
        end else begin
            tx_q  <= tx_d;
            rx_q  <= rx_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: host command handshake, read-address/read-data ordering, frame sequencing.
// state | meaning: IDLE accept | SEL select+cmd bit | SHIFT 10 bits | RD_WAIT slave latency | RECV 8 bits | GAP SS_n high
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_LATENCY = 3,
    parameter int MIN_GAP    = 2
) (
    input  logic              clk,
    input  logic              a_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              cmd_err,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam tmr_t SEL_INIT     = tmr_t'(1);
    localparam tmr_t RD_WAIT_INIT = tmr_t'(RD_LATENCY - 2);
    // The accepting IDLE cycle is itself one SS_n-high cycle, so GAP covers the rest.
    localparam tmr_t   GAP_INIT   = tmr_t'(MIN_GAP - 2);
    localparam state_e GAP_NEXT   = (MIN_GAP > 1) ? ST_GAP : ST_IDLE;

    state_e            state_q, state_d;
    tmr_t              timer_q, timer_d;
    logic [1:0]        cmd_q, cmd_d;
    logic              rd_pend_q, rd_pend_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              cmd_err_q, cmd_err_d;

    logic              accept, reject, start;
    logic              serial_out, tx_last, rx_last;
    logic [DATA_W-1:0] rx_next;

    assign accept = cmd_valid & cmd_ready_q;
    assign reject = accept & (((cmd == CMD_RD_DATA) & ~rd_pend_q) |
                              ((cmd == CMD_RD_ADDR) &  rd_pend_q));
    assign start  = accept & ~reject;

    spi_shift_reg u_shift (
        .clk        (clk),
        .a_rst_n    (a_rst_n),
        .load       (start),
        .frame      (build_frame(cmd, cmd_data)),
        .shift_en   (state_q == ST_SHIFT),
        .cnt_rst    (state_q == ST_RD_WAIT),
        .capture_en (state_q == ST_RECV),
        .serial_in  (MISO),
        .serial_out (serial_out),
        .rx_next    (rx_next),
        .tx_last    (tx_last),
        .rx_last    (rx_last)
    );

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            cmd_q       <= '0;
            rd_pend_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_q       <= cmd_d;
            rd_pend_q   <= rd_pend_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cmd_d       = cmd_q;
        rd_pend_d   = rd_pend_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        cmd_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_err_d = reject;
                if (start) begin
                    state_d = ST_SEL;
                    timer_d = SEL_INIT;
                    cmd_d   = cmd;
                end
            end
            ST_SEL: begin
                if (timer_q == '0) state_d = ST_SHIFT;
                else               timer_d = timer_q - tmr_t'(1);
            end
            ST_SHIFT: begin
                if (tx_last) begin
                    if (cmd_q == CMD_RD_DATA) begin
                        state_d = ST_RD_WAIT;
                        timer_d = RD_WAIT_INIT;
                    end else begin
                        state_d = GAP_NEXT;
                        timer_d = GAP_INIT;
                        if (cmd_q == CMD_RD_ADDR) rd_pend_d = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (timer_q == '0) state_d = ST_RECV;
                else               timer_d = timer_q - tmr_t'(1);
            end
            ST_RECV: begin
                if (rx_last) begin
                    state_d     = GAP_NEXT;
                    timer_d     = GAP_INIT;
                    rd_pend_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_next;
                end
            end
            ST_GAP: begin
                if (timer_q == '0) state_d = ST_IDLE;
                else               timer_d = timer_q - tmr_t'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // Pin outputs decode straight from the state flop so reset releases SS_n at once.
    always_comb begin
        SS_n = 1'b1;
        MOSI = 1'b0;
        case (state_q)
            ST_SEL, ST_SHIFT: begin
                SS_n = 1'b0;
                MOSI = serial_out;
            end
            ST_RD_WAIT, ST_RECV: SS_n = 1'b0;
            default: ;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (RD_LATENCY 3 and 4) each talking to a slave/RAM model.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid [2];
    logic [1:0] cmd       [2];
    logic [7:0] cmd_data  [2];
    logic       cmd_ready [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_data  [2];
    logic       cmd_err   [2];
    logic       busy      [2];
    logic       ss_n      [2];
    logic       mosi      [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int RL = (g == 0) ? 3 : 4;
        logic       miso_s = 1'b0;
        int         j = 0;
        logic [9:0] sh = '0;
        logic [7:0] addr_q = '0;
        logic [7:0] rdata = '0;
        logic [7:0] ram [256];

        spi_master_ctrl #(.RD_LATENCY(RL), .MIN_GAP(2)) u_dut (
            .clk       (clk),
            .a_rst_n   (rst_n),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd       (cmd[g]),
            .cmd_data  (cmd_data[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_data  (rsp_data[g]),
            .cmd_err   (cmd_err[g]),
            .busy      (busy[g]),
            .SS_n      (ss_n[g]),
            .MOSI      (mosi[g]),
            .MISO      (miso_s)
        );

        // Slave model: j numbers the upcoming rising edge since SS_n fell.
        initial begin
            forever begin
                @(negedge clk);
                if (!rst_n || ss_n[g]) begin
                    j      = 0;
                    miso_s = 1'b0;
                end else begin
                    j = j + 1;
                    if (j >= 3 && j <= 12) sh = {sh[8:0], mosi[g]};
                    if (j == 12) begin
                        case (sh[9:8])
                            2'b00, 2'b10: addr_q = sh[7:0];
                            2'b01:        ram[addr_q] = sh[7:0];
                            default:      rdata = ram[addr_q];
                        endcase
                    end
                    if (j >= 12 + RL && j < 20 + RL) miso_s = rdata[j - 12 - RL];
                    else                             miso_s = 1'b0;
                end
            end
        end
    end

    typedef struct {
        int         g;
        logic [1:0] c;
        logic [7:0] d;
        logic       err;
        logic       rsp;
        logic [7:0] rdat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic do_cmd(input int g, input logic [1:0] c, input logic [7:0] d,
                          output logic got_err, output int n_rsp,
                          output logic [7:0] got_data, output logic tmo);
        logic rdy_seen = 1'b0;
        logic ended    = 1'b0;
        got_err  = 1'b0;
        n_rsp    = 0;
        got_data = '0;
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready[g]) begin
                rdy_seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cmd_valid[g] = 1'b1;
        cmd[g]       = c;
        cmd_data[g]  = d;
        @(negedge clk);
        cmd_valid[g] = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (cmd_err[g])   got_err = 1'b1;
            if (rsp_valid[g]) begin
                n_rsp++;
                got_data = rsp_data[g];
            end
            if (!busy[g] && cmd_ready[g]) begin
                ended = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tmo = !(rdy_seen && ended);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic       e, t;
        int         nr;
        logic [7:0] dd;
        do_cmd(v.g, v.c, v.d, e, nr, dd, t);
        check({tag, "_timeout"}, t, 0);
        check({tag, "_cmd_err"}, e, v.err);
        check({tag, "_rsp_cnt"}, nr, v.rsp ? 1 : 0);
        if (v.rsp) check({tag, "_rsp_data"}, dd, v.rdat);
    endtask

    initial begin
        vec_t       tbl [$];
        vec_t       seq [$];
        int         low_cnt, rdy_low, acc, frames, hi, rv;
        int         gaps [$];
        logic [9:0] mbits;
        logic       prev, seen, pend;

        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            cmd_valid[g] = 1'b0;
            cmd[g]       = 2'b00;
            cmd_data[g]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_ss_n_%0d", g),      ss_n[g],      1);
            check($sformatf("rst_mosi_%0d", g),      mosi[g],      0);
            check($sformatf("rst_cmd_ready_%0d", g), cmd_ready[g], 0);
            check($sformatf("rst_rsp_valid_%0d", g), rsp_valid[g], 0);
            check($sformatf("rst_rsp_data_%0d", g),  rsp_data[g],  0);
            check($sformatf("rst_cmd_err_%0d", g),   cmd_err[g],   0);
            check($sformatf("rst_busy_%0d", g),      busy[g],      0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release_0", cmd_ready[0], 1);
        check("ready_after_release_1", cmd_ready[1], 1);
        @(negedge clk);

        // Write-address 0x3C: watch the wire for 14 cycles after the accept edge.
        cmd_valid[0] = 1'b1;
        cmd[0]       = CMD_WR_ADDR;
        cmd_data[0]  = 8'h3C;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        low_cnt = 0;
        rdy_low = 0;
        mbits   = '0;
        for (int i = 1; i <= 14; i++) begin
            if (!ss_n[0]) low_cnt++;
            if (!ss_n[0] && cmd_ready[0]) rdy_low++;
            if (i >= 3 && i <= 12) mbits = {mbits[8:0], mosi[0]};
            if (i == 1) check("wa_sel_mosi", mosi[0], 0);
            @(negedge clk);
        end
        check("wa_ss_low_cycles", low_cnt, 12);
        check("wa_mosi_bits", mbits, 10'h03C);
        check("wa_ready_while_low", rdy_low, 0);
        check("wa_slave_addr", g_dut[0].addr_q, 8'h3C);

        tbl.push_back('{0, CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{0, CMD_WR_ADDR, 8'h01, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{0, CMD_WR_DATA, 8'h3E, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{0, CMD_WR_ADDR, 8'h05, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{0, CMD_WR_DATA, 8'hA7, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{0, CMD_RD_ADDR, 8'h05, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{0, CMD_RD_DATA, 8'h00, 1'b0, 1'b1, 8'hA7});
        tbl.push_back('{0, CMD_RD_ADDR, 8'h01, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{0, CMD_RD_ADDR, 8'h02, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{0, CMD_RD_DATA, 8'h00, 1'b0, 1'b1, 8'h3E});
        tbl.push_back('{0, CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{0, CMD_WR_ADDR, 8'hFF, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{0, CMD_WR_DATA, 8'h00, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{0, CMD_RD_ADDR, 8'hFF, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{0, CMD_RD_DATA, 8'h00, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{1, CMD_WR_ADDR, 8'h40, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{1, CMD_WR_DATA, 8'h5A, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{1, CMD_RD_ADDR, 8'h40, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{1, CMD_RD_DATA, 8'h00, 1'b0, 1'b1, 8'h5A});
        tbl.push_back('{1, CMD_RD_DATA, 8'h00, 1'b1, 1'b0, 8'h00});
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));
        check("rd_pend_end_0", g_dut[0].u_dut.rd_pend_q, 0);
        check("rd_pend_end_1", g_dut[1].u_dut.rd_pend_q, 0);

        // Back-to-back writes with cmd_valid held high.
        acc = 0; frames = 0; hi = 0; rdy_low = 0;
        prev = 1'b1; seen = 1'b0; pend = 1'b0;
        cmd_valid[0] = 1'b1;
        cmd[0]       = CMD_WR_DATA;
        cmd_data[0]  = 8'h61;
        for (int cyc = 0; cyc < 150; cyc++) begin
            if (!ss_n[0]) begin
                if (prev) begin
                    if (seen) gaps.push_back(hi);
                    frames++;
                end
                seen = 1'b1;
                if (cmd_ready[0]) rdy_low++;
            end else begin
                hi = prev ? hi + 1 : 1;
            end
            prev = ss_n[0];
            if (pend) begin
                pend = 1'b0;
                if (acc == 3) cmd_valid[0] = 1'b0;
                else          cmd_data[0]  = cmd_data[0] + 8'h01;
            end
            if (cmd_valid[0] && cmd_ready[0]) begin
                acc++;
                pend = 1'b1;
            end
            if (acc == 3 && !pend && !cmd_valid[0] && !busy[0] && cmd_ready[0]) break;
            @(negedge clk);
        end
        cmd_valid[0] = 1'b0;
        check("b2b_frames", frames, 3);
        check("b2b_gap_count", gaps.size(), 2);
        check("b2b_gap0", (gaps.size() > 0) ? gaps[0] : -1, 2);
        check("b2b_gap1", (gaps.size() > 1) ? gaps[1] : -1, 2);
        check("b2b_ready_while_low", rdy_low, 0);
        check("b2b_ram_last", g_dut[0].ram[8'hFF], 8'h63);

        // Reset at the 4th MISO sample edge of a read-data frame.
        run_vec('{0, CMD_RD_ADDR, 8'h20, 1'b0, 1'b0, 8'h00}, "mr_rdaddr");
        cmd_valid[0] = 1'b1;
        cmd[0]       = CMD_RD_DATA;
        cmd_data[0]  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        check("mr_ss_low_before_rst", ss_n[0], 0);
        rst_n = 1'b0;
        #1;
        check("mr_ss_high_in_rst", ss_n[0], 1);
        check("mr_busy_in_rst", busy[0], 0);
        check("mr_rd_pend_in_rst", g_dut[0].u_dut.rd_pend_q, 0);
        rv = 0;
        repeat (3) begin
            @(negedge clk);
            rv += int'(rsp_valid[0]);
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            rv += int'(rsp_valid[0]);
        end
        check("mr_no_rsp_valid", rv, 0);
        seq.push_back('{0, CMD_WR_ADDR, 8'h20, 1'b0, 1'b0, 8'h00});
        seq.push_back('{0, CMD_WR_DATA, 8'hC3, 1'b0, 1'b0, 8'h00});
        seq.push_back('{0, CMD_RD_ADDR, 8'h20, 1'b0, 1'b0, 8'h00});
        seq.push_back('{0, CMD_RD_DATA, 8'h00, 1'b0, 1'b1, 8'hC3});
        foreach (seq[i]) run_vec(seq[i], $sformatf("mr_seq%0d", i));
        check("mr_rd_pend_end", g_dut[0].u_dut.rd_pend_q, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
